generic_sw_cntr_regs: RTL and testbench
=======================================

# generic_sw_cntr_regs

Parametrised register-ring block that extends the plain software-register file with two additions:
- a bank of hardware event counters;
- per-register write strobes.

It sits on the UDP register ring between the CPU-side ring master and user datapath modules. One instance serves both kinds of state that pipeline modules need:
- CPU-written configuration words;
- hardware-updated statistics, readable and clearable by the CPU.

## Interface
Parameters:
- UDP_REG_SRC_WIDTH, 2, width of the request source ID.
- TAG, 0, block tag compared against reg_addr_in[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH].
- REG_ADDR_WIDTH, 5, block-local address width; NUM_SW_REGS+NUM_CNTRS must be ≤ 2**REG_ADDR_WIDTH.
- NUM_SW_REGS, 4, software registers at local addresses 0..NUM_SW_REGS-1.
- NUM_CNTRS, 4, counters at local addresses NUM_SW_REGS..NUM_SW_REGS+NUM_CNTRS-1.
- CNTR_WIDTH, 32, counter width, 1..`CPCI_NF2_DATA_WIDTH; reads zero-extend.
- INC_WIDTH, 8, width of each per-cycle increment.
- CLR_ON_READ, 1, 1 = a counter read clears that counter.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- reg_req_in / reg_ack_in / reg_rd_wr_L_in  in  1 each  ring request, ack, read(1)/write(0).
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring address.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring source.
- reg_*_out  out  same widths as the corresponding inputs  registered ring outputs.
- software_regs  out  NUM_SW_REGS*32  concatenated software registers; register i occupies bits [32i+31:32i].
- sw_reg_wr  out  NUM_SW_REGS  one-cycle write strobe per software register.
- cntr_inc  in  NUM_CNTRS*INC_WIDTH  per-counter increment this cycle; counter j occupies slice j.

## Operation
- Hit condition: reg_req_in && !reg_ack_in && tag match.
  - If reg_ack_in is already set, the request is passed through untouched, even on a tag match.
- Every cycle, all reg_*_in are copied to reg_*_out. On a hit, the following fields are overridden:
  - reg_ack_out = 1.
  - reg_data_out depends on the access:
    - read of a software register: the register value;
    - read of a counter: the counter value;
    - read of an unmapped local address: 32'hDEAD_BEEF;
    - any write: reg_data_in.
- Writes:
  - Software register write: the register takes reg_data_in, and sw_reg_wr[i] pulses.
  - Counter write: the counter loads reg_data_in[CNTR_WIDTH-1:0].
  - Unmapped write: acked, no state change.
- Counters: every cycle, cnt_j ← min(cnt_j + cntr_inc_j, 2**CNTR_WIDTH-1).
  - Saturating arithmetic; the sum is computed at CNTR_WIDTH+1 bits; no wrap-around.
- Same-cycle collisions on counter j:
  - CPU write and increment: the write wins; that cycle's increment is discarded.
  - Read with CLR_ON_READ=1 and increment: the read returns the pre-increment value, and cnt_j ← cntr_inc_j. No event is lost.
  - Read with CLR_ON_READ=0: a normal increment.
- Reset values: all software registers 0, all counters 0, sw_reg_wr 0, and all reg_*_out 0.
  - Reset asserted mid-transaction drops the in-flight request; the ring master's timeout handles it.

## Timing
- Ring latency: exactly 1 cycle, in→out, for both hit and pass-through.
- Register read data is the pre-write, pre-increment state of the cycle in which the request is sampled.
- After a software register write at sample edge N:
  - software_regs shows the new value from edge N+1;
  - sw_reg_wr[i] is high for exactly the cycle after edge N+1, aligned with the new value.
- Counter updates take effect at the next edge. No combinational path runs from cntr_inc to any output.
- Back-to-back requests on consecutive cycles are supported; no stall.

## Structure
- The shared defines header supplies:
  - `CPCI_NF2_DATA_WIDTH and `UDP_REG_ADDR_WIDTH;
  - the constant DEAD_DATA = 32'hDEAD_BEEF, which belongs there alongside the width macros.
- One sub-module, sat_cntr, is generated NUM_CNTRS times.
  - Parameters: CNTR_WIDTH, INC_WIDTH.
  - Inputs: load, load_val, clr, inc.
  - Output: value.
  - Priority: load > clr > increment.
- Top level: address decode, ring pipeline register, software register file, strobe generation.

## Test plan
- Write 0x1234_5678 to software register 2, then read it back → write acked one cycle later with data echoed; software_regs[95:64]=0x12345678 and sw_reg_wr=4'b0100 for one cycle; the read returns 0x12345678.
- cntr_inc_0=3 for 10 cycles, then read counter 0 (local address 4) with CLR_ON_READ=1 while cntr_inc_0=3 → the read returns 30; the counter is 3 the next cycle.
- CNTR_WIDTH=8: load counter 1 with 0xFE, then hold cntr_inc_1=5 → the counter reads 0xFF and stays there.
- Read of local address 31 with TAG matching; separately, a request with tag≠TAG; separately, reg_ack_in=1 on a matching address → first read returns 0xDEADBEEF with ack=1; the other two pass through unmodified with no state change.
- Counter write of 0x10 in the same cycle as cntr_inc=7 → the counter equals 0x10, then increments normally afterwards.
- Assert reset mid-run → next cycle all outputs, software registers and counters are 0; sw_reg_wr stays 0.

Source files
------------

// File: rtl/generic_sw_cntr_regs_pkg.sv
// Shared ring widths, the unmapped-read filler word and the access-kind decode
// type used by generic_sw_cntr_regs.
package generic_sw_cntr_regs_pkg;

  localparam int CPCI_NF2_DATA_WIDTH = 32;
  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int SW_REG_WIDTH        = 32;

  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] DEAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ACC_UNMAPPED = 2'd0,
    ACC_SW       = 2'd1,
    ACC_CNTR     = 2'd2
  } acc_kind_e;

endpackage

// File: rtl/generic_sw_cntr_regs_sat_cntr.sv
// Saturating event counter: load beats clear, clear beats plain accumulate.
// A clear restarts the count from this cycle's increment so no event is lost.
module sat_cntr #(
  parameter int CNTR_WIDTH = 32,
  parameter int INC_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [CNTR_WIDTH-1:0] load_val,
  input  logic                  clr,
  input  logic [INC_WIDTH-1:0]  inc,
  output logic [CNTR_WIDTH-1:0] value
);

  localparam int SUM_WIDTH = ((CNTR_WIDTH > INC_WIDTH) ? CNTR_WIDTH : INC_WIDTH) + 1;
  localparam logic [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'({CNTR_WIDTH{1'b1}});

  logic [SUM_WIDTH-1:0]  base;
  logic [SUM_WIDTH-1:0]  sum;
  logic [CNTR_WIDTH-1:0] next_val;

  always_comb begin
    base     = clr ? '0 : SUM_WIDTH'(value);
    sum      = base + SUM_WIDTH'(inc);
    next_val = (sum > SAT_MAX) ? {CNTR_WIDTH{1'b1}} : sum[CNTR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else begin
      value <= next_val;
    end
  end

endmodule

// File: rtl/generic_sw_cntr_regs.sv
// Register-ring slave holding CPU-written software registers with write strobes
// plus a bank of saturating hardware event counters.
module generic_sw_cntr_regs
  import generic_sw_cntr_regs_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int NUM_SW_REGS       = 4,
  parameter int NUM_CNTRS         = 4,
  parameter int CNTR_WIDTH        = 32,
  parameter int INC_WIDTH         = 8,
  parameter int CLR_ON_READ       = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reg_req_in,
  input  logic                                  reg_ack_in,
  input  logic                                  reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]         reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0]        reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_in,
  output logic                                  reg_req_out,
  output logic                                  reg_ack_out,
  output logic                                  reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]         reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0]        reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]          reg_src_out,
  output logic [NUM_SW_REGS*SW_REG_WIDTH-1:0]   software_regs,
  output logic [NUM_SW_REGS-1:0]                sw_reg_wr,
  input  logic [NUM_CNTRS*INC_WIDTH-1:0]        cntr_inc
);

  localparam int TAG_WIDTH = UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;

  logic                           hit;
  logic [REG_ADDR_WIDTH-1:0]      local_addr;
  acc_kind_e                      acc_kind;
  logic [NUM_SW_REGS-1:0]         sw_sel;
  logic [NUM_CNTRS-1:0]           cntr_sel;
  logic [NUM_CNTRS-1:0]           cntr_load;
  logic [NUM_CNTRS-1:0]           cntr_clr;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rd_data;
  logic                           sw_write;
  logic [SW_REG_WIDTH-1:0]        sw_reg [NUM_SW_REGS];
  logic [CNTR_WIDTH-1:0]          cntr_val [NUM_CNTRS];
  logic [NUM_SW_REGS-1:0]         wr_pend;
  logic [SW_REG_WIDTH-1:0]        wr_data;

  assign local_addr = reg_addr_in[REG_ADDR_WIDTH-1:0];
  assign hit = reg_req_in && !reg_ack_in &&
               (reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TAG_WIDTH'(TAG));

  always_comb begin
    acc_kind = ACC_UNMAPPED;
    sw_sel   = '0;
    cntr_sel = '0;
    rd_data  = DEAD_DATA;
    for (int i = 0; i < NUM_SW_REGS; i++) begin
      if (int'(local_addr) == i) begin
        acc_kind  = ACC_SW;
        sw_sel[i] = 1'b1;
        rd_data   = CPCI_NF2_DATA_WIDTH'(sw_reg[i]);
      end
    end
    for (int j = 0; j < NUM_CNTRS; j++) begin
      if (int'(local_addr) == NUM_SW_REGS + j) begin
        acc_kind    = ACC_CNTR;
        cntr_sel[j] = 1'b1;
        rd_data     = CPCI_NF2_DATA_WIDTH'(cntr_val[j]);
      end
    end
  end

  assign sw_write  = hit && !reg_rd_wr_L_in && (acc_kind == ACC_SW);
  assign cntr_load = (hit && !reg_rd_wr_L_in && (acc_kind == ACC_CNTR)) ? cntr_sel : '0;
  assign cntr_clr  = (hit && reg_rd_wr_L_in && (CLR_ON_READ != 0)) ? cntr_sel : '0;

  // Software writes commit one edge after sampling so the strobe lines up with the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      wr_pend         <= '0;
      wr_data         <= '0;
      sw_reg_wr       <= '0;
      for (int i = 0; i < NUM_SW_REGS; i++) sw_reg[i] <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in | hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= (hit && reg_rd_wr_L_in) ? rd_data : reg_data_in;
      reg_src_out     <= reg_src_in;
      wr_pend         <= sw_write ? sw_sel : '0;
      wr_data         <= SW_REG_WIDTH'(reg_data_in);
      sw_reg_wr       <= wr_pend;
      for (int i = 0; i < NUM_SW_REGS; i++) begin
        if (wr_pend[i]) sw_reg[i] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_SW_REGS; i++) begin : g_sw_out
    assign software_regs[SW_REG_WIDTH*i +: SW_REG_WIDTH] = sw_reg[i];
  end

  for (genvar j = 0; j < NUM_CNTRS; j++) begin : g_cntr
    sat_cntr #(
      .CNTR_WIDTH (CNTR_WIDTH),
      .INC_WIDTH  (INC_WIDTH)
    ) u_sat_cntr (
      .clk      (clk),
      .reset    (reset),
      .load     (cntr_load[j]),
      .load_val (reg_data_in[CNTR_WIDTH-1:0]),
      .clr      (cntr_clr[j]),
      .inc      (cntr_inc[j*INC_WIDTH +: INC_WIDTH]),
      .value    (cntr_val[j])
    );
  end

endmodule

// File: tb/tb_generic_sw_cntr_regs.sv
// Scoreboard bench for generic_sw_cntr_regs (TAG=3, 8-bit counters, clear-on-read):
// directed scenarios followed by randomized ring traffic against a behavioural model.
module tb_generic_sw_cntr_regs;

  localparam int TAGV = 3;
  localparam int CMAX = 255;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [22:0]  reg_addr_in = '0;
  logic [31:0]  reg_data_in = '0;
  logic [1:0]   reg_src_in = '0;
  logic         reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0]  reg_addr_out;
  logic [31:0]  reg_data_out;
  logic [1:0]   reg_src_out;
  logic [127:0] software_regs;
  logic [3:0]   sw_reg_wr;
  logic [31:0]  cntr_inc = '0;

  generic_sw_cntr_regs #(
    .UDP_REG_SRC_WIDTH (2),
    .TAG               (TAGV),
    .REG_ADDR_WIDTH    (5),
    .NUM_SW_REGS       (4),
    .NUM_CNTRS         (4),
    .CNTR_WIDTH        (8),
    .INC_WIDTH         (8),
    .CLR_ON_READ       (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out),
    .software_regs   (software_regs),
    .sw_reg_wr       (sw_reg_wr),
    .cntr_inc        (cntr_inc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         req, ack, rd;
    logic [22:0]  addr;
    logic [31:0]  data;
    logic [1:0]   src;
    logic [127:0] sw;
    logic [3:0]   wr;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  // reference state: register contents, counter values, and a write waiting to land
  logic [31:0] m_sw [4];
  int          m_cnt [4];
  bit          pend_v;
  int          pend_i;
  logic [31:0] pend_d;

  function automatic logic [22:0] mk_addr(input int tag, input int la);
    logic [22:0] a;
    a = {tag[17:0], la[4:0]};
    return a;
  endfunction

  task automatic step(input bit rst, input bit req, input bit ack, input bit rd,
                      input logic [22:0] addr, input logic [31:0] data,
                      input logic [1:0] src, input logic [31:0] inc);
    exp_t        e;
    bit          hit;
    int          la, incj, v;
    logic [31:0] rd_val;
    @(negedge clk);
    reset = rst; reg_req_in = req; reg_ack_in = ack; reg_rd_wr_L_in = rd;
    reg_addr_in = addr; reg_data_in = data; reg_src_in = src; cntr_inc = inc;
    e = '0;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_sw[i] = '0; m_cnt[i] = 0; end
      pend_v = 0;
    end else begin
      e.req = req; e.ack = ack; e.rd = rd; e.addr = addr; e.data = data; e.src = src;
      hit = req && !ack && (int'(addr[22:5]) == TAGV);
      la = int'(addr[4:0]);
      if (la < 4) rd_val = m_sw[la];
      else if (la < 8) rd_val = 32'(m_cnt[la-4]);
      else rd_val = DEAD;
      if (hit) begin
        e.ack = 1'b1;
        if (rd) e.data = rd_val;
      end
      for (int j = 0; j < 4; j++) begin
        incj = int'(inc[8*j +: 8]);
        if (hit && !rd && la == 4 + j) m_cnt[j] = int'(data[7:0]);
        else if (hit && rd && la == 4 + j) m_cnt[j] = incj;
        else begin
          v = m_cnt[j] + incj;
          m_cnt[j] = (v > CMAX) ? CMAX : v;
        end
      end
      if (pend_v) begin
        m_sw[pend_i] = pend_d;
        e.wr[pend_i] = 1'b1;
      end
      pend_v = hit && !rd && la < 4;
      pend_i = la;
      pend_d = data;
      for (int i = 0; i < 4; i++) e.sw[32*i +: 32] = m_sw[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [31:0] inc);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, '0, '0, inc);
  endtask

  task automatic acc(input bit rd, input int la, input logic [31:0] data, input logic [31:0] inc);
    step(0, 1, 0, rd, mk_addr(TAGV, la), data, 2'd1, inc);
  endtask

  // monitor: one expected record per clock edge, compared just after the edge
  initial begin
    exp_t e;
    logic [60:0] got_ring, exp_ring;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got_ring = {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
        exp_ring = {e.req, e.ack, e.rd, e.addr, e.data, e.src};
        total++;
        if (got_ring !== exp_ring) begin
          bad++;
          $display("FAIL ring cyc=%0d got=%h exp=%h", cyc, got_ring, exp_ring);
        end
        total++;
        if (software_regs !== e.sw) begin
          bad++;
          $display("FAIL software_regs cyc=%0d got=%h exp=%h", cyc, software_regs, e.sw);
        end
        total++;
        if (sw_reg_wr !== e.wr) begin
          bad++;
          $display("FAIL sw_reg_wr cyc=%0d got=%b exp=%b", cyc, sw_reg_wr, e.wr);
        end
      end
    end
  end

  initial begin
    logic [31:0] inc;
    int la, tag;
    step(1, 0, 0, 0, '0, '0, '0, '0);
    step(1, 1, 0, 1, mk_addr(TAGV, 2), 32'h55, 2'd3, 32'h0101_0101);

    // software register write, strobe, readback
    acc(0, 2, 32'h1234_5678, '0);
    idle(2, '0);
    acc(1, 2, 32'h0, '0);
    idle(1, '0);

    // counter 0 accumulates, then clear-on-read while incrementing
    idle(10, 32'h0000_0003);
    acc(1, 4, 32'h0, 32'h0000_0003);
    acc(1, 4, 32'h0, 32'h0);

    // saturation of counter 1
    acc(0, 5, 32'h0000_00FE, '0);
    idle(3, 32'h0000_0500);
    acc(1, 5, 32'h0, 32'h0000_0500);
    acc(1, 5, 32'h0, '0);

    // unmapped read, foreign tag, already-acked request
    acc(1, 31, 32'h0, '0);
    step(0, 1, 0, 1, mk_addr(TAGV + 1, 2), 32'hA5A5_A5A5, 2'd2, '0);
    step(0, 1, 1, 0, mk_addr(TAGV, 0), 32'hCAFE_F00D, 2'd2, '0);
    acc(0, 9, 32'h1111_2222, '0);
    idle(2, '0);
    acc(1, 0, 32'h0, '0);

    // counter write collides with increment
    acc(0, 6, 32'h0000_0010, 32'h0007_0000);
    idle(1, 32'h0007_0000);
    acc(1, 6, 32'h0, '0);

    // back-to-back writes then reads
    acc(0, 1, 32'hAAAA_0001, '0);
    acc(0, 3, 32'hBBBB_0003, '0);
    acc(1, 1, 32'h0, '0);
    acc(1, 3, 32'h0, '0);
    acc(1, 3, 32'h0, '0);

    // reset in the middle of a pending write
    acc(0, 0, 32'h7777_7777, 32'h0909_0909);
    step(1, 1, 0, 1, mk_addr(TAGV, 4), 32'h0, 2'd1, 32'h0909_0909);
    idle(2, '0);
    for (int i = 0; i < 8; i++) acc(1, i, 32'h0, '0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 4; j++)
        inc[8*j +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      la  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      tag = ($urandom_range(0, 99) < 85) ? TAGV : int'($urandom_range(0, 7));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, mk_addr(tag, la), $urandom, 2'($urandom_range(0, 3)), inc);
    end
    for (int i = 0; i < 8; i++) acc(1, i, 32'h0, '0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
